// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLatch,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake of the byte FIFO feeding the UART transmitter.
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;

    // master: the consumer that pops bytes; slave: the FIFO itself
    modport master (input fifo_empty, input fifo_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter; bit_end marks the last clock of each serial bit.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = run && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run || restart || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO one at a time and sends each as a UART frame on txd.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    fifo_uart_tx_if.master        fifo_bus,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done,
    output logic [15:0]           frame_cnt
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              bit_end;
    logic              run;
    logic              restart;

    assign run     = state_q inside {StStart, StData, StParity, StStop};
    assign restart = (state_d != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .restart(restart),
        .bit_end(bit_end)
    );

    // Read strobe decoded straight from the state register so it cannot glitch.
    assign fifo_bus.fifo_rd = (state_q == StReq);
    assign busy             = (state_q != StIdle);
    assign frame_cnt        = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;
        frame_cnt_d = frame_cnt_q;
        txd         = STOP_LVL;
        tx_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && !fifo_bus.fifo_empty) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StLatch;
            end
            StLatch: begin
                shift_d  = fifo_bus.fifo_data;
                parity_d = (^fifo_bus.fifo_data) ^ PARITY_ODD;
                state_d  = StStart;
            end
            StStart: begin
                txd = START_LVL;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                txd = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = PARITY_EN ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                txd = parity_q;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                txd = STOP_LVL;
                // bit_idx counts stop bits here
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        tx_done     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        bit_idx_d   = '0;
                        state_d     = StIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: three transmitter configurations fed by behavioural FIFOs.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  en_v;
    logic [2:0]  txd_v, busy_v, done_v, rd_v;
    logic [15:0] fcnt_v [3];

    // behavioural FIFOs, one per DUT; registered read
    logic [7:0]  mem   [3][64];
    logic [5:0]  wr_p  [3] = '{6'd0, 6'd0, 6'd0};
    logic [5:0]  rd_p  [3] = '{6'd0, 6'd0, 6'd0};
    logic [7:0]  fdata [3];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int exp_cnt [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rd_v[i] && rd_p[i] != wr_p[i]) begin
                fdata[i] <= mem[i][rd_p[i]];
                rd_p[i]  <= rd_p[i] + 6'd1;
            end
        end
    end

    fifo_uart_tx_if if_a ();
    fifo_uart_tx_if if_b ();
    fifo_uart_tx_if if_c ();

    assign if_a.fifo_empty = (wr_p[0] == rd_p[0]);
    assign if_b.fifo_empty = (wr_p[1] == rd_p[1]);
    assign if_c.fifo_empty = (wr_p[2] == rd_p[2]);
    assign if_a.fifo_data  = fdata[0];
    assign if_b.fifo_data  = fdata[1];
    assign if_c.fifo_data  = fdata[2];
    assign rd_v[0]         = if_a.fifo_rd;
    assign rd_v[1]         = if_b.fifo_rd;
    assign rd_v[2]         = if_c.fifo_rd;

    fifo_uart_tx #(
        .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .fifo_bus(if_a.master),
        .txd(txd_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .frame_cnt(fcnt_v[0])
    );

    fifo_uart_tx #(
        .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .fifo_bus(if_b.master),
        .txd(txd_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .frame_cnt(fcnt_v[1])
    );

    fifo_uart_tx #(
        .CLKS_PER_BIT(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .fifo_bus(if_c.master),
        .txd(txd_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .frame_cnt(fcnt_v[2])
    );

    function automatic int cpb(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic bit cfg_pe(input int d);
        return d != 0;
    endfunction

    function automatic bit cfg_po(input int d);
        return d == 2;
    endfunction

    function automatic int cfg_sb(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // Reference: serial bit list of one frame, index 0 = start bit.
    function automatic void frame_bits(input logic [7:0] b, input bit pe, input bit po,
                                       input int sb, output logic [11:0] bits, output int n);
        bits = '1;
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = b[i];
            n++;
        end
        if (pe) begin
            bits[n] = (($countones(b) % 2) == 1) ^ po;
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            bits[n] = 1'b1;
            n++;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][wr_p[d]] = b;
        wr_p[d] = wr_p[d] + 6'd1;
    endtask

    // Waits for the read pulse, then checks every cycle of the frame that follows.
    task automatic check_frame(input int d, input logic [11:0] bits, input int n,
                               input bit drop_en, output int rd_cyc);
        int c, t, errs, dones, done_at;
        c = cpb(d);
        t = 0;
        errs = 0;
        dones = 0;
        done_at = -1;
        rd_cyc = 0;
        while (rd_v[d] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (rd_v[d] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rd_timeout dut%0d: actual=no fifo_rd required=fifo_rd", d);
            return;
        end
        rd_cyc = cyc;
        @(negedge clk);
        check($sformatf("latch_cycle dut%0d", d), {29'd0, rd_v[d], busy_v[d], txd_v[d]}, 32'd3);
        for (int k = 0; k < n * c; k++) begin
            @(negedge clk);
            if (drop_en && k == 0) en_v[d] = 1'b0;
            if (txd_v[d] !== bits[k / c] || rd_v[d] !== 1'b0) errs++;
            if (done_v[d] === 1'b1) begin
                dones++;
                done_at = k;
            end
        end
        check($sformatf("txd_wave dut%0d", d), errs, 0);
        check($sformatf("tx_done_count dut%0d", d), dones, 1);
        check($sformatf("tx_done_pos dut%0d", d), done_at, n * c - 1);
        @(negedge clk);
        check($sformatf("idle_after dut%0d", d), {31'd0, busy_v[d]}, 32'd0);
    endtask

    typedef struct {
        int          d;
        logic [7:0]  data;
        logic [11:0] bits;
        int          n;
    } vec_t;

    initial begin
        vec_t        tbl [5];
        logic [11:0] bits;
        logic [7:0]  bv [4];
        int          nb, rc, t, viol, d, nq, push_cyc;
        int          rcs [3];

        // expected frames, LSB = start bit: {pad, stop, [parity], data, start}
        tbl[0] = '{0, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 10};
        tbl[1] = '{1, 8'hA5, {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        tbl[2] = '{1, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
        tbl[3] = '{2, 8'h3C, {1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12};
        tbl[4] = '{2, 8'h01, {1'b1, 1'b1, 1'b0, 8'h01, 1'b0}, 12};

        rst_n = 1'b0;
        en_v = 3'b000;
        exp_cnt = '{0, 0, 0};
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_state dut%0d", i),
                  {12'd0, fcnt_v[i], txd_v[i], busy_v[i], done_v[i], rd_v[i]},
                  {12'd0, 16'd0, 4'b1000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            d = tbl[i].d;
            push(d, tbl[i].data);
            en_v[d] = 1'b1;
            check_frame(d, tbl[i].bits, tbl[i].n, 1'b0, rc);
            en_v[d] = 1'b0;
            exp_cnt[d]++;
            check($sformatf("frame_cnt vec%0d", i), fcnt_v[d], exp_cnt[d]);
        end

        // three queued bytes drain in order, one read per 43 cycles
        bv[0] = 8'h00; bv[1] = 8'hFF; bv[2] = 8'h55;
        for (int j = 0; j < 3; j++) push(0, bv[j]);
        en_v[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            frame_bits(bv[j], 1'b0, 1'b0, 1, bits, nb);
            check_frame(0, bits, nb, 1'b0, rcs[j]);
            exp_cnt[0]++;
        end
        en_v[0] = 1'b0;
        check("rd_spacing_01", rcs[1] - rcs[0], 43);
        check("rd_spacing_12", rcs[2] - rcs[1], 43);
        check("frame_cnt_burst", fcnt_v[0], exp_cnt[0]);
        check("fifo_drained", {26'd0, wr_p[0] - rd_p[0]}, 32'd0);

        // empty FIFO with enable held: nothing may move
        en_v[0] = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_v[0] !== 1'b0 || txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) viol++;
        end
        check("empty_idle", viol, 0);
        push_cyc = cyc;
        push(0, 8'h3C);
        frame_bits(8'h3C, 1'b0, 1'b0, 1, bits, nb);
        check_frame(0, bits, nb, 1'b0, rc);
        exp_cnt[0]++;
        check("empty_fall_to_rd", rc - push_cyc, 1);
        en_v[0] = 1'b0;

        // asynchronous reset in the middle of data bit 4 of 0xA5
        push(0, 8'hA5);
        en_v[0] = 1'b1;
        t = 0;
        while (rd_v[0] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reset_test_rd", {31'd0, rd_v[0]}, 32'd1);
        repeat (23) @(negedge clk);
        check("pre_reset", {30'd0, txd_v[0], busy_v[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", {12'd0, fcnt_v[0], txd_v[0], busy_v[0], done_v[0], rd_v[0]},
              {12'd0, 16'd0, 4'b1000});
        exp_cnt = '{0, 0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_v[0] !== 1'b0 || txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) viol++;
        end
        check("post_reset_idle", viol, 0);
        en_v[0] = 1'b0;

        // enable dropped at the start bit: current frame finishes, no further read
        push(0, 8'h81);
        push(0, 8'h42);
        en_v[0] = 1'b1;
        frame_bits(8'h81, 1'b0, 1'b0, 1, bits, nb);
        check_frame(0, bits, nb, 1'b1, rc);
        exp_cnt[0]++;
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (rd_v[0] !== 1'b0 || busy_v[0] !== 1'b0) viol++;
        end
        check("no_read_after_en_drop", viol, 0);
        check("fifo_left_one", {26'd0, wr_p[0] - rd_p[0]}, 32'd1);
        check("frame_cnt_en_drop", fcnt_v[0], exp_cnt[0]);
        en_v[0] = 1'b1;
        frame_bits(8'h42, 1'b0, 1'b0, 1, bits, nb);
        check_frame(0, bits, nb, 1'b0, rc);
        exp_cnt[0]++;
        en_v[0] = 1'b0;

        // random bursts against the frame model
        for (int r = 0; r < 8; r++) begin
            d = (r % 2 == 0) ? 0 : 2;
            nq = $urandom_range(1, 4);
            for (int j = 0; j < nq; j++) begin
                bv[j] = 8'($urandom);
                push(d, bv[j]);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            en_v[d] = 1'b1;
            for (int j = 0; j < nq; j++) begin
                frame_bits(bv[j], cfg_pe(d), cfg_po(d), cfg_sb(d), bits, nb);
                check_frame(d, bits, nb, 1'b0, rc);
                exp_cnt[d]++;
            end
            en_v[d] = 1'b0;
            check($sformatf("frame_cnt rand%0d", r), fcnt_v[d], exp_cnt[d]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
